// File: rtl/nor_mis_chain_seq.sv
// Two NOR2 inverter chains driven by a registered stimulus sequencer, used to
// exercise multiple-input-switching on a final NOR2; counts output transitions.
module nor_mis_chain_seq #(
    parameter int STAGES = 5,
    parameter int CNT_W  = 8,
    parameter int REPS_W = 8,
    parameter int EDGE_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              first_sel,
    input  logic [CNT_W-1:0]  offset,
    input  logic [CNT_W-1:0]  hold,
    input  logic [REPS_W-1:0] reps,
    output logic              stim_a1,
    output logic              stim_a2,
    output logic              myout,
    output logic              busy,
    output logic              done,
    output logic [EDGE_W-1:0] edge_cnt
);

    typedef enum logic [2:0] {IDLE, SKEW, HIGH, LOW, DONE} state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [CNT_W-1:0]    off_q, off_d;
    logic [CNT_W-1:0]    hold_q, hold_d;
    logic [REPS_W-1:0]   reps_q, reps_d;
    logic                sel_q, sel_d;
    logic                lead_d, lag_d;
    logic                a1_d, a2_d;
    logic                accept;
    logic                sync1, sync2, sync3;
    logic [2:0]          post_q;
    logic                window;

    // Each stage is its own scalar net so the chain stays a true cell chain.
    for (genvar g = 0; g < STAGES; g++) begin : g_stage
        logic y1, y2;
        if (g == 0) begin : g_first
            assign y1 = ~(stim_a1 | 1'b0);
            assign y2 = ~(stim_a2 | 1'b0);
        end else begin : g_next
            assign y1 = ~(g_stage[g-1].y1 | 1'b0);
            assign y2 = ~(g_stage[g-1].y2 | 1'b0);
        end
    end

    assign myout  = ~(g_stage[STAGES-1].y1 | g_stage[STAGES-1].y2);
    assign busy   = (state_q == SKEW) || (state_q == HIGH) || (state_q == LOW);
    assign done   = (state_q == DONE);
    assign accept = (state_q == IDLE) && start;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        off_d   = off_q;
        hold_d  = hold_q;
        reps_d  = reps_q;
        sel_d   = sel_q;
        lead_d  = sel_q ? stim_a2 : stim_a1;
        lag_d   = sel_q ? stim_a1 : stim_a2;
        case (state_q)
            IDLE: begin
                if (start) begin
                    off_d  = offset;
                    hold_d = hold;
                    reps_d = reps;
                    sel_d  = first_sel;
                    if (reps == '0) begin
                        state_d = DONE;
                    end else begin
                        lead_d = 1'b1;
                        if (offset == '0) begin
                            lag_d   = 1'b1;
                            state_d = HIGH;
                            cnt_d   = hold;
                        end else begin
                            state_d = SKEW;
                            cnt_d   = offset - 1'b1;
                        end
                    end
                end
            end
            SKEW: begin
                if (cnt_q == '0) begin
                    lag_d   = 1'b1;
                    state_d = HIGH;
                    cnt_d   = hold_q;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            HIGH: begin
                if (cnt_q == '0) begin
                    lead_d  = 1'b0;
                    lag_d   = 1'b0;
                    state_d = LOW;
                    cnt_d   = hold_q;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            LOW: begin
                if (cnt_q == '0) begin
                    reps_d = reps_q - 1'b1;
                    if (reps_q == REPS_W'(1)) begin
                        state_d = DONE;
                    end else begin
                        lead_d = 1'b1;
                        if (off_q == '0) begin
                            lag_d   = 1'b1;
                            state_d = HIGH;
                            cnt_d   = hold_q;
                        end else begin
                            state_d = SKEW;
                            cnt_d   = off_q - 1'b1;
                        end
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        a1_d = sel_d ? lag_d : lead_d;
        a2_d = sel_d ? lead_d : lag_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            off_q   <= '0;
            hold_q  <= '0;
            reps_q  <= '0;
            sel_q   <= 1'b0;
            stim_a1 <= 1'b0;
            stim_a2 <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            off_q   <= off_d;
            hold_q  <= hold_d;
            reps_q  <= reps_d;
            sel_q   <= sel_d;
            stim_a1 <= a1_d;
            stim_a2 <= a2_d;
        end
    end

    // Counting stays open a few cycles past DONE so the synchroniser latency
    // does not drop the final transition of a run.
    assign window = busy || (state_q == DONE) || (post_q != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1    <= 1'b0;
            sync2    <= 1'b0;
            sync3    <= 1'b0;
            post_q   <= '0;
            edge_cnt <= '0;
        end else begin
            sync1 <= myout;
            sync2 <= sync1;
            sync3 <= sync2;
            if (accept) begin
                post_q <= '0;
            end else if (state_q == DONE) begin
                post_q <= 3'd4;
            end else if (post_q != '0) begin
                post_q <= post_q - 1'b1;
            end
            if (accept) begin
                edge_cnt <= '0;
            end else if (window && (sync2 != sync3) && (edge_cnt != '1)) begin
                edge_cnt <= edge_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_nor_mis_chain_seq.sv
// Randomized scenario bench for nor_mis_chain_seq: two instances (odd and even
// chain length, wide and narrow edge counter) checked against a waveform model.
module tb_nor_mis_chain_seq;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       first_sel = 1'b0;
    logic [7:0] offset = '0;
    logic [7:0] hold = '0;
    logic [7:0] reps = '0;

    logic        a1_m, a2_m, my_m, busy_m, done_m;
    logic [15:0] ecnt_m;
    logic        a1_s, a2_s, my_s, busy_s, done_s;
    logic [3:0]  ecnt_s;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    nor_mis_chain_seq #(.STAGES(5), .CNT_W(8), .REPS_W(8), .EDGE_W(16)) u_main (
        .clk(clk), .rst_n(rst_n), .start(start), .first_sel(first_sel),
        .offset(offset), .hold(hold), .reps(reps),
        .stim_a1(a1_m), .stim_a2(a2_m), .myout(my_m), .busy(busy_m),
        .done(done_m), .edge_cnt(ecnt_m)
    );

    nor_mis_chain_seq #(.STAGES(4), .CNT_W(8), .REPS_W(8), .EDGE_W(4)) u_sat (
        .clk(clk), .rst_n(rst_n), .start(start), .first_sel(first_sel),
        .offset(offset), .hold(hold), .reps(reps),
        .stim_a1(a1_s), .stim_a2(a2_s), .myout(my_s), .busy(busy_s),
        .done(done_s), .edge_cnt(ecnt_s)
    );

    // Expected {a1, a2, busy, done} t cycles after the accepting edge.
    function automatic logic [3:0] model(int t, bit sel, int off, int hld, int rp);
        int  period, r;
        bit  lead, lag, bsy, dn;
        period = off + 2 * (hld + 1);
        lead = 0; lag = 0; bsy = 0; dn = 0;
        if (rp == 0) begin
            dn = (t == 0);
        end else begin
            if (t < rp * period) begin
                bsy  = 1;
                r    = t % period;
                lead = (r < off + hld + 1);
                lag  = (r >= off) && (r < off + hld + 1);
            end
            dn = (t == rp * period);
        end
        return {sel ? lag : lead, sel ? lead : lag, bsy, dn};
    endfunction

    // Odd chains invert, even chains pass through, then the final NOR2.
    function automatic logic exp_myout(logic a1, logic a2, int stages);
        return (stages % 2 == 1) ? (a1 & a2) : ~(a1 | a2);
    endfunction

    function automatic int sat(int v, int maxv);
        return (v > maxv) ? maxv : v;
    endfunction

    task automatic test_sequence(input string name, input bit sel, input int off,
                                 input int hld, input int rp, input bit noisy);
        int         last;
        logic [3:0] e;
        logic       em;
        last = (rp == 0) ? 0 : rp * (off + 2 * (hld + 1));
        @(negedge clk);
        first_sel = sel;
        offset    = 8'(off);
        hold      = 8'(hld);
        reps      = 8'(rp);
        start     = 1'b1;
        for (int t = 0; t <= last + 6; t++) begin
            @(posedge clk);
            #1;
            e  = model(t, sel, off, hld, rp);
            em = exp_myout(e[3], e[2], 5);
            vectors++;
            if ({a1_m, a2_m, busy_m, done_m, my_m} !== {e, em}) begin
                miscompares++;
                $display("FAIL %s main t=%0d a1,a2,busy,done,myout got %b want %b",
                         name, t, {a1_m, a2_m, busy_m, done_m, my_m}, {e, em});
            end
            em = exp_myout(e[3], e[2], 4);
            vectors++;
            if ({a1_s, a2_s, busy_s, done_s, my_s} !== {e, em}) begin
                miscompares++;
                $display("FAIL %s sat t=%0d a1,a2,busy,done,myout got %b want %b",
                         name, t, {a1_s, a2_s, busy_s, done_s, my_s}, {e, em});
            end
            if (noisy && t < last) begin
                start     = 1'($urandom_range(0, 1));
                first_sel = 1'($urandom_range(0, 1));
                offset    = 8'($urandom);
                hold      = 8'($urandom);
                reps      = 8'($urandom);
            end else begin
                start = 1'b0;
            end
        end
        vectors++;
        if (ecnt_m !== 16'(sat(2 * rp, 65535))) begin
            miscompares++;
            $display("FAIL %s main edge_cnt got %0d want %0d", name, ecnt_m, sat(2 * rp, 65535));
        end
        vectors++;
        if (ecnt_s !== 4'(sat(2 * rp, 15))) begin
            miscompares++;
            $display("FAIL %s sat edge_cnt got %0d want %0d", name, ecnt_s, sat(2 * rp, 15));
        end
    endtask

    task automatic check_reset_outputs(input string name);
        vectors++;
        if ({a1_m, a2_m, busy_m, done_m, my_m, ecnt_m} !== {4'b0000, 1'b0, 16'd0}) begin
            miscompares++;
            $display("FAIL %s main a1,a2,busy,done,myout,edge_cnt got %b %b %b %b %b %0d want 0 0 0 0 0 0",
                     name, a1_m, a2_m, busy_m, done_m, my_m, ecnt_m);
        end
        vectors++;
        if ({a1_s, a2_s, busy_s, done_s, my_s, ecnt_s} !== {4'b0000, 1'b1, 4'd0}) begin
            miscompares++;
            $display("FAIL %s sat a1,a2,busy,done,myout,edge_cnt got %b %b %b %b %b %0d want 0 0 0 0 1 0",
                     name, a1_s, a2_s, busy_s, done_s, my_s, ecnt_s);
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        #3;
        check_reset_outputs("reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset_release");
    endtask

    task automatic test_basic;
        test_sequence("basic", 1'b0, 3, 2, 1, 1'b0);
    endtask

    task automatic test_simultaneous;
        test_sequence("simultaneous", 1'b0, 0, 0, 2, 1'b0);
        test_sequence("simultaneous_sel1", 1'b1, 0, 1, 3, 1'b1);
    endtask

    task automatic test_lead_a2;
        test_sequence("lead_a2_busy_start", 1'b1, 5, 1, 2, 1'b1);
    endtask

    task automatic test_zero_reps;
        test_sequence("zero_reps", 1'b0, 4, 3, 0, 1'b0);
    endtask

    task automatic test_reset_mid;
        @(negedge clk);
        first_sel = 1'b0;
        offset    = 8'd2;
        hold      = 8'd4;
        reps      = 8'd3;
        start     = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        vectors++;
        if ({a1_m, a2_m, busy_m} !== 3'b111) begin
            miscompares++;
            $display("FAIL reset_mid in_high a1,a2,busy got %b want 111", {a1_m, a2_m, busy_m});
        end
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("reset_mid_abort");
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            vectors++;
            if ({done_m, done_s, busy_m, busy_s} !== 4'b0000) begin
                miscompares++;
                $display("FAIL reset_mid hold cyc=%0d done/busy got %b want 0000",
                         i, {done_m, done_s, busy_m, busy_s});
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        test_sequence("reset_mid_restart", 1'b0, 2, 4, 3, 1'b0);
    endtask

    task automatic test_saturate;
        test_sequence("max_counts", 1'b1, 255, 255, 8, 1'b1);
    endtask

    task automatic test_random;
        for (int k = 0; k < 8; k++) begin
            test_sequence("random", 1'($urandom_range(0, 1)), int'($urandom_range(0, 7)),
                          int'($urandom_range(0, 5)), int'($urandom_range(0, 4)),
                          1'($urandom_range(0, 1)));
        end
    endtask

    task automatic test_back_to_back;
        test_sequence("back_to_back_a", 1'b0, 1, 0, 1, 1'b0);
        test_sequence("back_to_back_b", 1'b1, 2, 1, 2, 1'b0);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_simultaneous();
        test_lead_a2();
        test_zero_reps();
        test_reset_mid();
        test_back_to_back();
        test_random();
        test_saturate();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/nor_mis_chain_seq.md
NOR_MIS_CHAIN_SEQ -- requirements
Module: nor_mis_chain_seq

Interface
REQ-001 SHALL have parameter STAGES, default 5: number of NOR2 inverter stages per channel chain (>=1).
REQ-002 SHALL have parameter CNT_W, default 8: width of offset and hold fields.
REQ-003 SHALL have parameter REPS_W, default 8: width of repetition field.
REQ-004 SHALL have parameter EDGE_W, default 16: width of output edge counter.
REQ-005 clk  in  1  single clock; all state on rising edge.
REQ-006 rst_n  in  1  asynchronous, active-low reset.
REQ-007 start  in  1  one-cycle request to run a stimulus sequence.
REQ-008 first_sel  in  1  0: channel A1 leads; 1: channel A2 leads.
REQ-009 offset  in  CNT_W  lead-to-lag skew in clk cycles.
REQ-010 hold  in  CNT_W  high/low phase extension in clk cycles.
REQ-011 reps  in  REPS_W  number of rise/fall repetitions.
REQ-012 stim_a1, stim_a2  out  1 each  registered chain inputs.
REQ-013 myout  out  1  final NOR2 output (combinational, asynchronous).
REQ-014 busy  out  1  high while sequence is running.
REQ-015 done  out  1  one-cycle pulse at sequence completion.
REQ-016 edge_cnt  out  EDGE_W  number of myout transitions counted in current run.

Function
REQ-017 Each channel SHALL be a chain of STAGES NOR2 cells, A2 pin tied 0, stim_aX driving stage 0.
REQ-018 myout SHALL be NOR2 of channel-1 last stage (A1) and channel-2 last stage (A2); no register on path.
REQ-019 FSM states SHALL be IDLE, SKEW, HIGH, LOW, DONE.
REQ-020 offset, hold, reps, first_sel SHALL be latched when start is accepted; later input changes ignored until IDLE.
REQ-021 start SHALL be accepted only in IDLE; start while busy ignored.
REQ-022 Accepted start with reps=0: next state DONE, no stimulus transition, edge_cnt cleared.
REQ-023 Accepted start at edge E0 with reps>0: leading stim 1 from E0; state SKEW.
REQ-024 SKEW: lagging stim rises at E0+offset; offset=0 -> both rise at E0 (simultaneous MIS case), SKEW skipped.
REQ-025 HIGH: both stims 1 for hold+1 cycles after lagging rise, then both fall together, state LOW.
REQ-026 LOW: both 0 for hold+1 cycles; then reps counter decrements; nonzero -> leading rises, SKEW/HIGH; zero -> DONE.
REQ-027 DONE SHALL last one cycle: done=1, busy=0, then IDLE.
REQ-028 busy SHALL be 1 in SKEW, HIGH, LOW; 0 in IDLE, DONE.
REQ-029 Offset and hold counters SHALL be CNT_W wide, down-counting, no wrap (max values usable, e.g. 255 for CNT_W=8).
REQ-030 myout SHALL pass through a 2-flop synchroniser; edge_cnt increments on each change of the synchronised value while busy or within 4 cycles after DONE.
REQ-031 edge_cnt SHALL clear on accepted start and saturate at all-ones (no wrap).
REQ-032 Stimulus waveform SHALL be glitch-free: each stim changes at most once per clock edge, driven from flops only.

Reset
REQ-033 rst_n low SHALL immediately force IDLE, stim_a1=stim_a2=0, busy=0, done=0, edge_cnt=0, synchroniser flops cleared.
REQ-034 Reset asserted mid-sequence SHALL abort it with no done pulse; first start after release runs a full new sequence.
REQ-035 myout after reset SHALL settle to NOR of the two chain ends with both stims 0 (1 for even STAGES, 0 for odd).

Verification
REQ-036 STAGES=5, first_sel=0, offset=3, hold=2, reps=1, start at E0 -> a1 rises E0, a2 rises E3, both fall E6, done at E9, edge_cnt=2.
REQ-037 offset=0, reps=2, hold=0 -> a1/a2 rise together E0 and E2, fall E1 and E3, done E4, edge_cnt=4.
REQ-038 first_sel=1, offset=5 -> a2 rises 5 cycles before a1; start pulses during busy produce no restart.
REQ-039 reps=0 -> done one cycle after start, stims stay 0, edge_cnt=0.
REQ-040 rst_n low during HIGH of reps=3 run -> stims 0 and busy 0 same cycle, no done; next start runs 3 reps.
REQ-041 offset=255, hold=255, reps=255 with EDGE_W=4 -> counters do not wrap, edge_cnt saturates at 15.
